framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/framebuffer_writer_if.sv | 25 ++
 rtl/framebuffer_writer.sv | 199 +++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_writer_if.sv
// Command and framebuffer-write bus for framebuffer_writer.
// master: command source / RAM-side observer; slave: the writer block.
interface framebuffer_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [3:0]  cmd_color;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [3:0]  ram_wdata;
    logic        done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, ram_we, ram_addr, ram_wdata, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, ram_we, ram_addr, ram_wdata, done
    );
endinterface

// File: rtl/framebuffer_writer.sv
// Rectangle-fill engine for a linear H_RES x V_RES palette framebuffer.
// A command is clipped once, then one pixel is written per cycle in raster
// order with an incrementally generated address.
// Optional macro FB_CLEAR_EN adds clear_req/clear_color: a full-screen clear
// that reuses the fill path as a H_RES x V_RES rectangle at (0,0).
module framebuffer_writer #(
    parameter int H_RES = 800,
    parameter int V_RES = 480
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef FB_CLEAR_EN
    input  logic                 clear_req,
    input  logic [3:0]           clear_color,
`endif
    framebuffer_writer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [9:0]  w_q, w_d;
    logic [8:0]  h_q, h_d;
    logic [3:0]  color_q, color_d;
    logic [10:0] x_end_q, x_end_d;
    logic [9:0]  y_end_q, y_end_d;
    logic [10:0] cur_x_q, cur_x_d;
    logic [9:0]  cur_y_q, cur_y_d;
    logic [18:0] line_addr_q, line_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [18:0] ram_addr_q, ram_addr_d;
    logic [3:0]  ram_wdata_q, ram_wdata_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic        in_idle;
    logic        accept;
    logic [10:0] x_sum;
    logic [9:0]  y_sum;
    logic [10:0] x_lim;
    logic [9:0]  y_lim;
    logic        skip;
    logic        last_x;
    logic        last_y;
    logic [18:0] row_start;

    // Acceptance, clipping arithmetic and end-of-line/frame detection.
    always_comb begin
        in_idle   = (state_q == IDLE) && cmd_ready_q;
`ifdef FB_CLEAR_EN
        accept    = in_idle && (bus.cmd_valid || clear_req);
`else
        accept    = in_idle && bus.cmd_valid;
`endif
        x_sum     = {1'b0, x_q} + {1'b0, w_q};
        y_sum     = {1'b0, y_q} + {1'b0, h_q};
        x_lim     = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
        y_lim     = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
        skip      = (w_q == 10'd0) || (h_q == 9'd0) ||
                    ({1'b0, x_q} >= 11'(H_RES)) || ({1'b0, y_q} >= 10'(V_RES));
        last_x    = (cur_x_q + 11'd1) >= x_end_q;
        last_y    = (cur_y_q + 10'd1) >= y_end_q;
        // Multiply only once per command, in CLIP; the pixel loop just adds.
        row_start = 19'(y_q) * 19'(H_RES) + 19'(x_q);
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            line_addr_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            line_addr_q <= line_addr_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Next-state: IDLE -> CLIP -> (FILL ->) DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CLIP;
            CLIP: state_d = skip ? DONE : FILL;
            FILL: if (last_x && last_y) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and counters, registered so they line up with the state they describe.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x_end_d     = x_end_q;
        y_end_d     = y_end_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        line_addr_d = line_addr_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        done_d      = (state_d == DONE);
        cmd_ready_d = (state_d == IDLE);

        case (state_q)
            IDLE: begin
`ifdef FB_CLEAR_EN
                if (in_idle && clear_req) begin
                    x_d     = '0;
                    y_d     = '0;
                    w_d     = 10'(H_RES);
                    h_d     = 9'(V_RES);
                    color_d = clear_color;
                end else if (accept) begin
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                end
`else
                if (accept) begin
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                end
`endif
            end
            CLIP: begin
                x_end_d     = x_lim;
                y_end_d     = y_lim;
                cur_x_d     = {1'b0, x_q};
                cur_y_d     = {1'b0, y_q};
                line_addr_d = row_start;
                if (!skip) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = row_start;
                    ram_wdata_d = color_q;
                end
            end
            FILL: begin
                if (!last_x) begin
                    cur_x_d    = cur_x_q + 11'd1;
                    ram_addr_d = ram_addr_q + 19'd1;
                    ram_we_d   = 1'b1;
                end else if (!last_y) begin
                    cur_x_d     = {1'b0, x_q};
                    cur_y_d     = cur_y_q + 10'd1;
                    line_addr_d = line_addr_q + 19'(H_RES);
                    ram_addr_d  = line_addr_q + 19'(H_RES);
                    ram_we_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: directed table, hand sequences
// for held cmd_valid and mid-fill reset, then randomized commands against a
// clip-and-raster reference model.
module tb_framebuffer_writer;
    localparam int H = 800;
    localparam int V = 480;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    framebuffer_writer_if bus();

`ifdef FB_CLEAR_EN
    logic       clear_req = 1'b0;
    logic [3:0] clear_color = 4'd0;
`endif

    framebuffer_writer #(.H_RES(H), .V_RES(V)) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef FB_CLEAR_EN
        .clear_req   (clear_req),
        .clear_color (clear_color),
`endif
        .bus         (bus)
    );

    typedef struct packed { int x; int y; int w; int h; int color; } cmd_t;
    typedef struct packed { cmd_t c; int n; int first; int last; } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int obs_n, obs_first, obs_last;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: clip to the screen, then list addresses in raster order.
    function automatic void build_model(input cmd_t c);
        int xe, ye;
        exp_q.delete();
        if (c.w == 0 || c.h == 0 || c.x >= H || c.y >= V) return;
        xe = (c.x + c.w < H) ? c.x + c.w : H;
        ye = (c.y + c.h < V) ? c.y + c.h : V;
        for (int yy = c.y; yy < ye; yy++)
            for (int xx = c.x; xx < xe; xx++)
                exp_q.push_back(yy * H + xx);
    endfunction

    task automatic drive_fields(input cmd_t c);
        bus.cmd_x     = 10'(c.x);
        bus.cmd_y     = 9'(c.y);
        bus.cmd_w     = 10'(c.w);
        bus.cmd_h     = 9'(c.h);
        bus.cmd_color = 4'(c.color);
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input cmd_t c);
        int t = 0;
        drive_fields(c);
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) check("accept_timeout", 0, 1);
        @(posedge clock);
    endtask

    // Checks CLIP cycle, every write, done pulse and the return to IDLE.
    task automatic respond(input cmd_t c, input bit hold, input cmd_t nxt);
        build_model(c);
        @(negedge clock);
        if (hold) drive_fields(nxt);
        else bus.cmd_valid = 1'b0;
        check("clip_we", int'(bus.ram_we), 0);
        check("clip_ready", int'(bus.cmd_ready), 0);
        check("clip_done", int'(bus.done), 0);
        obs_n = 0; obs_first = -1; obs_last = -1;
        foreach (exp_q[i]) begin
            @(negedge clock);
            if (bus.ram_we === 1'b1) begin
                obs_n++;
                if (obs_first < 0) obs_first = int'(bus.ram_addr);
                obs_last = int'(bus.ram_addr);
            end
            check("fill_we", int'(bus.ram_we), 1);
            check("fill_addr", int'(bus.ram_addr), exp_q[i]);
            check("fill_data", int'(bus.ram_wdata), c.color);
            check("fill_done", int'(bus.done), 0);
        end
        @(negedge clock);
        check("done_pulse", int'(bus.done), 1);
        check("done_we", int'(bus.ram_we), 0);
        if (exp_q.size() > 0) check("addr_hold", int'(bus.ram_addr), exp_q[exp_q.size()-1]);
        @(negedge clock);
        check("done_clear", int'(bus.done), 0);
        check("ready_back", int'(bus.cmd_ready), 1);
        check("idle_we", int'(bus.ram_we), 0);
    endtask

    vec_t tbl[10];
    cmd_t none, a, b, r, rc;

    initial begin
        none = '{0, 0, 0, 0, 0};
        tbl[0] = '{'{10, 20, 3, 2, 5},        6, 16010, 16812};
        tbl[1] = '{'{798, 479, 10, 10, 10},   2, 383998, 383999};
        tbl[2] = '{'{10, 20, 0, 2, 1},        0, -1, -1};
        tbl[3] = '{'{800, 20, 3, 2, 1},       0, -1, -1};
        tbl[4] = '{'{10, 20, 3, 0, 1},        0, -1, -1};
        tbl[5] = '{'{10, 480, 3, 2, 1},       0, -1, -1};
        tbl[6] = '{'{0, 0, 1, 1, 15},         1, 0, 0};
        tbl[7] = '{'{0, 5, 800, 1, 2},        800, 4000, 4799};
        tbl[8] = '{'{795, 10, 5, 2, 4},       10, 8795, 9599};
        tbl[9] = '{'{1023, 511, 1023, 511, 6}, 0, -1, -1};

        bus.cmd_valid = 1'b0;
        drive_fields(none);

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", int'(bus.cmd_ready), 0);
        check("rst_we", int'(bus.ram_we), 0);
        check("rst_addr", int'(bus.ram_addr), 0);
        check("rst_wdata", int'(bus.ram_wdata), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b1;
        #1 check("ready_before_edge", int'(bus.cmd_ready), 0);
        @(negedge clock);
        check("ready_after_edge", int'(bus.cmd_ready), 1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].c);
            respond(tbl[i].c, 1'b0, none);
            check("tbl_count", obs_n, tbl[i].n);
            if (tbl[i].n > 0) begin
                check("tbl_first", obs_first, tbl[i].first);
                check("tbl_last", obs_last, tbl[i].last);
            end
        end

        // cmd_valid held with new fields during a fill: taken only back in IDLE
        a = '{100, 100, 4, 3, 9};
        b = '{5, 6, 2, 2, 1};
        send(a);
        respond(a, 1'b1, b);
        send(b);
        respond(b, 1'b0, none);

        // Reset during a 100x1 fill after four writes
        r = '{0, 0, 100, 1, 7};
        send(r);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("rstfill_clip_we", int'(bus.ram_we), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rstfill_we", int'(bus.ram_we), 1);
            check("rstfill_addr", int'(bus.ram_addr), k);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("abort_we", int'(bus.ram_we), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_ready", int'(bus.cmd_ready), 0);
        repeat (2) begin
            @(negedge clock);
            check("abort_hold_we", int'(bus.ram_we), 0);
            check("abort_hold_done", int'(bus.done), 0);
        end
        reset = 1'b1;
        #1 check("rel_ready_low", int'(bus.cmd_ready), 0);
        @(negedge clock);
        check("rel_ready", int'(bus.cmd_ready), 1);
        check("rel_done", int'(bus.done), 0);
        check("rel_we", int'(bus.ram_we), 0);

        // Randomized commands, biased to cross the right and bottom edges
        for (int i = 0; i < 40; i++) begin
            rc.x = int'($urandom_range(0, 820));
            rc.y = int'($urandom_range(0, 490));
            rc.w = int'($urandom_range(0, 40));
            rc.h = int'($urandom_range(0, 12));
            rc.color = int'($urandom_range(0, 15));
            send(rc);
            respond(rc, 1'b0, none);
        end

`ifdef FB_CLEAR_EN
        begin
            int bad = 0;
            int t = 0;
            clear_req = 1'b1;
            clear_color = 4'd3;
            drive_fields('{1, 1, 2, 2, 9});
            bus.cmd_valid = 1'b1;
            @(posedge clock);
            @(negedge clock);
            clear_req = 1'b0;
            bus.cmd_valid = 1'b0;
            for (int i = 0; i < H * V; i++) begin
                @(negedge clock);
                if (!(bus.ram_we === 1'b1 && int'(bus.ram_addr) == i && bus.ram_wdata == 4'd3)) bad++;
            end
            check("clear_bad_writes", bad, 0);
            @(negedge clock);
            check("clear_done", int'(bus.done), 1);
            while (bus.cmd_ready !== 1'b1 && t < 10) begin
                @(negedge clock);
                t++;
            end
            check("clear_ready", int'(bus.cmd_ready), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
